// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the quota-based round-robin AHB arbiter.
// Also used by builds that define AHB_WRR_ARB_SPLIT_EN (SPLIT response codes).
package ahb_arb_pkg;

    localparam int MAX_MASTERS = 16;
    localparam int IDX_W       = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    function automatic logic [MAX_MASTERS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return MAX_MASTERS'(1) << idx;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: the first requester after 'last' wins,
// wrapping modulo NMASTERS.
module ahb_rr_picker
    import ahb_arb_pkg::*;
#(
    parameter int NMASTERS = 16
) (
    input  logic [NMASTERS-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic                valid,
    output logic [IDX_W-1:0]    idx
);

    logic [MAX_MASTERS-1:0] req_ext;
    logic [IDX_W:0]         cand;

    always_comb begin
        req_ext                 = '0;
        req_ext[NMASTERS-1:0]   = req;
        valid                   = 1'b0;
        idx                     = '0;
        cand                    = '0;
        // last < NMASTERS, so last+k < 2*NMASTERS and one subtraction wraps it
        for (int k = 1; k <= NMASTERS; k++) begin
            cand = {1'b0, last} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NMASTERS)) begin
                cand = cand - (IDX_W+1)'(NMASTERS);
            end
            if (!valid && req_ext[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_wrr_arbiter.sv
// Quota-based round-robin AHB arbiter: holds a grant for up to QUOTA beats,
// hands over on HREADY, honours HLOCKx. Define AHB_WRR_ARB_SPLIT_EN for SPLIT masking.
module ahb_wrr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NMASTERS = 16,
    parameter int QUOTA    = 4
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NMASTERS-1:0] HBUSREQx,
    input  logic [NMASTERS-1:0] HLOCKx,
    input  logic [1:0]          HTRANS,
    input  logic                HREADY,
`ifdef AHB_WRR_ARB_SPLIT_EN
    input  logic [1:0]          HRESP,
    input  logic [NMASTERS-1:0] HSPLIT,
`endif
    output logic [NMASTERS-1:0] HGRANTx,
    output logic [3:0]          HMASTER,
    output logic                HMASTLOCK
);

    localparam int               CW       = $clog2(QUOTA + 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(QUOTA);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NMASTERS - 1);

    arb_state_e          state_q, state_d;
    logic [NMASTERS-1:0] grant_q, grant_d;
    logic [NMASTERS-1:0] mask_q;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    hmaster_q, hmaster_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                hmastlock_q, hmastlock_d;

    logic [MAX_MASTERS-1:0] req_ext, lock_ext, owner_oh, win_oh;
    logic [NMASTERS-1:0]    pick_req;
    logic [IDX_W-1:0]       pick_ptr, win_idx;
    logic                   win_valid, beat, owner_req, owner_lock;
    logic                   split_rel, release_now;

    always_comb begin
        req_ext                = '0;
        req_ext[NMASTERS-1:0]  = HBUSREQx;
        lock_ext               = '0;
        lock_ext[NMASTERS-1:0] = HLOCKx;
        owner_oh               = idx_onehot(owner_q);
        owner_req              = req_ext[owner_q];
        owner_lock             = lock_ext[owner_q];
        beat                   = HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
        // During a tenure the search starts after the owner, and the owner is never its own successor
        pick_ptr               = (state_q == ST_GRANT) ? owner_q : last_q;
        pick_req               = HBUSREQx & ~mask_q;
        if (state_q == ST_GRANT) begin
            pick_req = pick_req & ~owner_oh[NMASTERS-1:0];
        end
    end

    ahb_rr_picker #(
        .NMASTERS(NMASTERS)
    ) u_picker (
        .req   (pick_req),
        .last  (pick_ptr),
        .valid (win_valid),
        .idx   (win_idx)
    );

`ifdef AHB_WRR_ARB_SPLIT_EN
    logic [NMASTERS-1:0] mask_d;

    assign split_rel = HREADY && (state_q == ST_GRANT) && (HRESP == HRESP_SPLIT);

    always_comb begin
        mask_d = mask_q;
        if (split_rel) begin
            mask_d = mask_d | owner_oh[NMASTERS-1:0];
        end
        mask_d = mask_d & ~HSPLIT;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign split_rel = 1'b0;
    assign mask_q    = '0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        release_now = 1'b0;
        win_oh      = idx_onehot(win_idx);
        if (HREADY) begin
            hmastlock_d = owner_lock && (state_q == ST_GRANT);
            if (state_q == ST_GRANT) begin
                hmaster_d = owner_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_d = ST_GRANT;
                        grant_d = win_oh[NMASTERS-1:0];
                        owner_d = win_idx;
                        cnt_d   = '0;
                    end
                end
                ST_GRANT: begin
                    release_now = (!owner_req && !owner_lock)
                               || (cnt_q == CNT_MAX && !owner_lock && win_valid)
                               || split_rel;
                    if (release_now) begin
                        last_d = owner_q;
                        cnt_d  = '0;
                        if (win_valid) begin
                            grant_d = win_oh[NMASTERS-1:0];
                            owner_d = win_idx;
                        end else begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Alone on the bus: start a fresh quota; locked with waiters: stay saturated
                        if (!win_valid) begin
                            cnt_d = '0;
                        end
                    end else if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            hmaster_q   <= '0;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// Bench for ahb_wrr_arbiter: directed scenarios plus random traffic against a
// tenure-level reference model (owner, beats used, last owner, split mask).
module tb_ahb_wrr_arbiter;

    localparam int N = 16;
    localparam int Q = 4;

    logic           hclk = 1'b0;
    logic           hreset;
    logic [N-1:0]   hbusreq, hlock;
    logic [1:0]     htrans;
    logic           hready;
`ifdef AHB_WRR_ARB_SPLIT_EN
    logic [1:0]     hresp;
    logic [N-1:0]   hsplit;
`endif
    logic [N-1:0]   hgrant;
    logic [3:0]     hmaster;
    logic           hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner = -1 means nobody holds the bus
    int       m_owner, m_last, m_beats, m_hmaster;
    bit       m_lock;
    bit [N-1:0] m_mask;

    ahb_wrr_arbiter #(.NMASTERS(N), .QUOTA(Q)) dut (
        .HCLK      (hclk),
        .HRESET    (hreset),
        .HBUSREQx  (hbusreq),
        .HLOCKx    (hlock),
        .HTRANS    (htrans),
        .HREADY    (hready),
`ifdef AHB_WRR_ARB_SPLIT_EN
        .HRESP     (hresp),
        .HSPLIT    (hsplit),
`endif
        .HGRANTx   (hgrant),
        .HMASTER   (hmaster),
        .HMASTLOCK (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input bit [N-1:0] req, input int from);
        for (int k = 1; k <= N; k++) begin
            int i = (from + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_beats   = 0;
        m_hmaster = 0;
        m_lock    = 1'b0;
        m_mask    = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_update();
        bit [N-1:0] avail, others;
        int  w;
        bit  drop, quota, split;
        split = 1'b0;
`ifdef AHB_WRR_ARB_SPLIT_EN
        split = hready && (m_owner >= 0) && (hresp == 2'b11);
`endif
        if (hready) begin
            if (m_owner >= 0) m_hmaster = m_owner;
            m_lock = (m_owner >= 0) && hlock[m_owner];
            avail  = hbusreq & ~m_mask;
            if (m_owner < 0) begin
                w = rr_pick(avail, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_beats = 0;
                end
            end else begin
                others          = avail;
                others[m_owner] = 1'b0;
                w     = rr_pick(others, m_owner);
                drop  = !hbusreq[m_owner] && !hlock[m_owner];
                quota = (m_beats == Q) && !hlock[m_owner] && (w >= 0);
                if (drop || quota || split) begin
                    if (split) m_mask[m_owner] = 1'b1;
                    m_last  = m_owner;
                    m_owner = w;
                    m_beats = 0;
                end else if (m_beats == Q && w < 0) begin
                    m_beats = 0;
                end else if (htrans[1] && m_beats < Q) begin
                    m_beats++;
                end
            end
        end
`ifdef AHB_WRR_ARB_SPLIT_EN
        m_mask &= ~hsplit;
`endif
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] lk,
                          input logic [1:0] tr, input logic rdy);
        hbusreq = req;
        hlock   = lk;
        htrans  = tr;
        hready  = rdy;
`ifdef AHB_WRR_ARB_SPLIT_EN
        hresp   = 2'b00;
        hsplit  = '0;
`endif
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge hclk);
        #1;
        check({tag, ".grant"},  32'(hgrant),    32'(exp_grant()));
        check({tag, ".hmaster"}, 32'(hmaster),  32'(m_hmaster));
        check({tag, ".mlock"},  32'(hmastlock), 32'(m_lock));
        check({tag, ".onehot"}, 32'($countones(hgrant) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        set_in('0, '0, 2'b00, 1'b1);
        model_reset();
        repeat (2) @(posedge hclk);
        #1;
        check("reset.grant",   32'(hgrant),    32'd0);
        check("reset.hmaster", 32'(hmaster),   32'd0);
        check("reset.mlock",   32'(hmastlock), 32'd0);
        hreset = 1'b0;
    endtask

    initial begin
        bit saw4;
        hreset = 1'b1;
        set_in('0, '0, 2'b00, 1'b1);
        do_reset();

        // Single requester: one-cycle grant latency, HMASTER follows on the next HREADY edge
        set_in(16'h0001, '0, 2'b10, 1'b1);
        step("t1");
        check("t1.first_grant", 32'(hgrant), 32'h0001);
        step("t1b");
        check("t1.hmaster0", 32'(hmaster), 32'd0);

        // Masters 2 and 5 rotate on quota with no idle gap
        do_reset();
        set_in(16'h0024, '0, 2'b10, 1'b1);
        for (int i = 0; i < 24; i++) begin
            step("t2");
            check("t2.nogap", 32'(hgrant != '0), 32'd1);
            if (i == 4)  check("t2.still2",  32'(hgrant), 32'h0004);
            if (i == 5)  check("t2.to5",     32'(hgrant), 32'h0020);
            if (i == 10) check("t2.back2",   32'(hgrant), 32'h0004);
        end

        // Master 3 alone keeps the bus across quota boundaries
        do_reset();
        set_in(16'h0008, '0, 2'b11, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step("t3");
            check("t3.held", 32'(hgrant), 32'h0008);
        end

        // Locked master 1 blocks rotation to master 7 until the lock drops
        do_reset();
        set_in(16'h0082, 16'h0002, 2'b10, 1'b1);
        for (int i = 0; i < 13; i++) begin
            step("t4");
            check("t4.held1", 32'(hgrant), 32'h0002);
            if (i >= 1) check("t4.mlock", 32'(hmastlock), 32'd1);
        end
        set_in(16'h0082, '0, 2'b10, 1'b1);
        step("t4r");
        check("t4.to7", 32'(hgrant), 32'h0080);

        // HREADY low freezes a quota-exhausted tenure while master 9 waits
        do_reset();
        set_in(16'h0008, '0, 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) step("t5a");
        set_in(16'h0208, '0, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("t5f");
            check("t5.frozen_grant",   32'(hgrant),  32'h0008);
            check("t5.frozen_hmaster", 32'(hmaster), 32'd3);
        end
        hready = 1'b1;
        step("t5h");
        check("t5.to9", 32'(hgrant), 32'h0200);

        // Asynchronous reset in the middle of a tenure; pointer restarts at N-1
        do_reset();
        set_in(16'h4001, '0, 2'b10, 1'b1);
        for (int i = 0; i < 12; i++) step("t6a");
        #2;
        hreset = 1'b1;
        model_reset();
        #1;
        check("t6.async_grant",   32'(hgrant),    32'd0);
        check("t6.async_hmaster", 32'(hmaster),   32'd0);
        check("t6.async_mlock",   32'(hmastlock), 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        set_in(16'h4001, '0, 2'b10, 1'b1);
        step("t6b");
        check("t6.restart0", 32'(hgrant), 32'h0001);

`ifdef AHB_WRR_ARB_SPLIT_EN
        // SPLIT masks master 4 until HSPLIT[4] releases it
        do_reset();
        set_in(16'h0050, '0, 2'b10, 1'b1);
        step("t7a");
        check("t7.grant4", 32'(hgrant), 32'h0010);
        hresp = 2'b11;
        step("t7s");
        check("t7.left4", 32'(hgrant), 32'h0040);
        hresp = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step("t7m");
            check("t7.masked", 32'(hgrant), 32'h0040);
        end
        hsplit = 16'h0010;
        step("t7c");
        hsplit = '0;
        saw4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step("t7u");
            if (hgrant == 16'h0010) saw4 = 1'b1;
        end
        check("t7.regrant4", 32'(saw4), 32'd1);
`endif

        // Random traffic against the model
        do_reset();
        set_in('0, '0, 2'b00, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) hbusreq[i] = ~hbusreq[i];
            end
            hlock  = ($urandom_range(0, 3) == 0) ? (hbusreq & N'($urandom) & N'($urandom)) : '0;
            htrans = 2'($urandom_range(0, 3));
            hready = ($urandom_range(0, 4) != 0);
`ifdef AHB_WRR_ARB_SPLIT_EN
            hresp  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
            hsplit = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
`endif
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
